// File: rtl/cache_miss_ctrl.sv
// Miss handler: optional victim write-back, byte fetch, then a one-cycle fill to the cache.
// Latency: clean miss fill 1+wait cycles after accept; dirty 2+2*wait (1+wait with WB_BUFFER_EN).
// Backpressure: busy holds off new misses until IDLE; mem_req stays up until mem_ack.
module cache_miss_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              miss_req,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic              victim_dirty,
    input  logic [ADDR_W-1:0] victim_addr,
    input  logic [DATA_W-1:0] victim_data,
    output logic              busy,
    output logic              fill_valid,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [7:0]        miss_count,
    output logic [7:0]        wb_count
);

`ifdef WB_BUFFER_EN
    typedef enum logic [2:0] {IDLE, WRITEBACK, FETCH, FILL, DRAIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, FILL} state_t;
`endif

    state_t            state;
    logic [ADDR_W-1:0] req_addr;
`ifdef WB_BUFFER_EN
    logic              buf_dirty;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            req_addr   <= '0;
            busy       <= 1'b0;
            fill_valid <= 1'b0;
            fill_addr  <= '0;
            fill_data  <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            miss_count <= 8'd0;
            wb_count   <= 8'd0;
`ifdef WB_BUFFER_EN
            buf_dirty  <= 1'b0;
            buf_addr   <= '0;
            buf_data   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (miss_req && !busy) begin
                        req_addr <= miss_addr;
                        busy     <= 1'b1;
                        mem_req  <= 1'b1;
                        if (miss_count != 8'hFF)
                            miss_count <= miss_count + 8'd1;
`ifdef WB_BUFFER_EN
                        // Victim is parked; the fetch goes out first and the write drains after fill.
                        buf_dirty <= victim_dirty;
                        buf_addr  <= victim_addr;
                        buf_data  <= victim_data;
                        mem_we    <= 1'b0;
                        mem_addr  <= miss_addr;
                        state     <= FETCH;
`else
                        mem_wdata <= victim_data;
                        if (victim_dirty) begin
                            mem_we   <= 1'b1;
                            mem_addr <= victim_addr;
                            state    <= WRITEBACK;
                        end else begin
                            mem_we   <= 1'b0;
                            mem_addr <= miss_addr;
                            state    <= FETCH;
                        end
`endif
                    end
                end
                WRITEBACK: begin
                    // mem_req stays high so the read follows the write back-to-back.
                    if (mem_ack) begin
                        if (wb_count != 8'hFF)
                            wb_count <= wb_count + 8'd1;
                        mem_we   <= 1'b0;
                        mem_addr <= req_addr;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        fill_data  <= mem_rdata;
                        fill_addr  <= req_addr;
                        fill_valid <= 1'b1;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        state      <= FILL;
                    end
                end
                FILL: begin
                    fill_valid <= 1'b0;
`ifdef WB_BUFFER_EN
                    if (buf_dirty) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= buf_addr;
                        mem_wdata <= buf_data;
                        buf_dirty <= 1'b0;
                        state     <= DRAIN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
`else
                    busy  <= 1'b0;
                    state <= IDLE;
`endif
                end
`ifdef WB_BUFFER_EN
                DRAIN: begin
                    if (mem_ack) begin
                        if (wb_count != 8'hFF)
                            wb_count <= wb_count + 8'd1;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Scoreboard bench for cache_miss_ctrl: stimulus pushes expected memory ops and fills, a monitor pops and compares.
module tb_cache_miss_ctrl;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       miss_req = 1'b0;
    logic [4:0] miss_addr = '0;
    logic       victim_dirty = 1'b0;
    logic [4:0] victim_addr = '0;
    logic [7:0] victim_data = '0;
    logic       busy, fill_valid, mem_req, mem_we;
    logic [4:0] fill_addr, mem_addr;
    logic [7:0] fill_data, mem_wdata, miss_count, wb_count;
    logic       mem_ack;
    logic [7:0] mem_rdata;

    cache_miss_ctrl dut (
        .clock(clock), .resetn(resetn),
        .miss_req(miss_req), .miss_addr(miss_addr),
        .victim_dirty(victim_dirty), .victim_addr(victim_addr), .victim_data(victim_data),
        .busy(busy), .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .miss_count(miss_count), .wb_count(wb_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct packed {
        logic       we;
        logic [4:0] addr;
        logic [7:0] wdata;
    } mem_exp_t;

    typedef struct packed {
        logic [4:0] addr;
        logic [7:0] data;
        int         at;
    } fill_exp_t;

    mem_exp_t  mem_q[$];
    fill_exp_t fill_q[$];

    int   errors = 0;
    int   checks = 0;
    int   fills_seen = 0;
    int   wait_n = 0;
    bit   ack_en = 1'b1;
    int   stray_n = 0;
    logic [7:0] rd_val = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory model: acks after wait_n idle request cycles; stray_n forces unsolicited ack pulses.
    initial begin : responder
        int cnt;
        cnt = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clock);
            if (mem_ack) cnt = 0;
            mem_ack = 1'b0;
            if (stray_n > 0) begin
                mem_ack = 1'b1;
                stray_n--;
            end else if (ack_en && mem_req) begin
                if (cnt == wait_n) begin
                    mem_ack = 1'b1;
                    mem_rdata = rd_val;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin : monitor
        mem_exp_t  me;
        fill_exp_t fe;
        forever begin
            @(negedge clock);
            #2;
            if (mem_req && mem_ack) begin
                check("mem_op_expected", mem_q.size() != 0, 1);
                if (mem_q.size() != 0) begin
                    me = mem_q.pop_front();
                    check("mem_we", mem_we, me.we);
                    check("mem_addr", mem_addr, me.addr);
                    if (me.we) check("mem_wdata", mem_wdata, me.wdata);
                end
            end
            if (fill_valid) begin
                fills_seen++;
                check("fill_expected", fill_q.size() != 0, 1);
                if (fill_q.size() != 0) begin
                    fe = fill_q.pop_front();
                    check("fill_addr", fill_addr, fe.addr);
                    check("fill_data", fill_data, fe.data);
                    check("fill_cycle", cyc, fe.at);
                end
            end
        end
    end

    // Drives one miss; returns on the negedge after the accepting edge with miss_req dropped.
    task automatic start_req(input logic [4:0] a, input logic d, input logic [4:0] va,
                             input logic [7:0] vd, input logic [7:0] rd, input int w);
        int acc;
        int lat;
        rd_val = rd;
        wait_n = w;
        @(negedge clock);
        miss_addr = a;
        victim_dirty = d;
        victim_addr = va;
        victim_data = vd;
        miss_req = 1'b1;
        acc = cyc + 1;
`ifdef WB_BUFFER_EN
        lat = 1 + w;
        mem_q.push_back('{we: 1'b0, addr: a, wdata: 8'h00});
        if (d) mem_q.push_back('{we: 1'b1, addr: va, wdata: vd});
`else
        lat = d ? 2 + 2 * w : 1 + w;
        if (d) mem_q.push_back('{we: 1'b1, addr: va, wdata: vd});
        mem_q.push_back('{we: 1'b0, addr: a, wdata: 8'h00});
`endif
        fill_q.push_back('{addr: a, data: rd, at: acc + lat});
        @(negedge clock);
        miss_req = 1'b0;
        check("busy_after_accept", busy, 1);
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        while (busy && n < lim) begin
            @(negedge clock);
            n++;
        end
        check("idle_within_budget", busy, 0);
        check("scoreboard_drained", mem_q.size() + fill_q.size(), 0);
    endtask

    task automatic issue(input logic [4:0] a, input logic d, input logic [4:0] va,
                         input logic [7:0] vd, input logic [7:0] rd, input int w);
        start_req(a, d, va, vd, rd, w);
        wait_idle(50);
    endtask

    initial begin : main
        int fills_before;
        // Reset values while resetn is held low.
        #12;
        check("rst_busy", busy, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_fill_valid", fill_valid, 0);
        check("rst_miss_count", miss_count, 0);
        check("rst_wb_count", wb_count, 0);
        @(negedge clock);
        resetn = 1'b1;

        // Clean miss, zero-wait memory.
        issue(5'b10_011, 1'b0, 5'b00_011, 8'h00, 8'hA5, 0);
        check("clean_miss_count", miss_count, 1);
        check("clean_wb_count", wb_count, 0);

        // Dirty miss, two wait cycles per memory access.
        issue(5'h13, 1'b1, 5'b01_011, 8'h3C, 8'h5A, 2);
        check("dirty_miss_count", miss_count, 2);
        check("dirty_wb_count", wb_count, 1);

        // Fetch stalled for 10 cycles: request lines frozen, no fill.
        start_req(5'h07, 1'b0, 5'h0F, 8'h00, 8'h77, 10);
        for (int i = 0; i < 10; i++) begin
            check("stall_mem_req", mem_req, 1);
            check("stall_mem_addr", mem_addr, 5'h07);
            check("stall_mem_we", mem_we, 0);
            check("stall_no_fill", fill_valid, 0);
            @(negedge clock);
        end
        wait_idle(50);
        check("stall_miss_count", miss_count, 3);

        // Stray ack while idle is ignored.
        fills_before = fills_seen;
        #1 stray_n = 1;
        repeat (4) @(negedge clock);
        check("stray_busy", busy, 0);
        check("stray_mem_req", mem_req, 0);
        check("stray_no_fill", fills_seen, fills_before);
        check("stray_miss_count", miss_count, 3);

        // Reset asserted mid-transaction between clock edges.
        ack_en = 1'b0;
        start_req(5'h15, 1'b1, 5'h05, 8'hC3, 8'h99, 0);
        @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        check("midrst_mem_req", mem_req, 0);
        check("midrst_busy", busy, 0);
        check("midrst_miss_count", miss_count, 0);
        check("midrst_wb_count", wb_count, 0);
        check("midrst_mem_addr", mem_addr, 0);
        mem_q.delete();
        fill_q.delete();
        @(negedge clock);
        resetn = 1'b1;
        ack_en = 1'b1;
        fills_before = fills_seen;
        #1 stray_n = 2;
        repeat (5) @(negedge clock);
        check("late_ack_no_fill", fills_seen, fills_before);
        check("late_ack_busy", busy, 0);

        // Saturation: 300 clean misses.
        for (int i = 0; i < 300; i++)
            issue({i[1:0], i[4:2]}, 1'b0, 5'h00, 8'h00, i[7:0], 0);
        check("sat_miss_count", miss_count, 255);
        check("sat_wb_count", wb_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
